// File: rtl/branch_resolver.sv
// Branch resolution unit: decodes jump/call/return/conditional requests, drives a
// one-cycle redirect, manages a circular return-address stack and a pipeline-flush window.
module branch_resolver #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 20,
  parameter int DIRECT_WIDTH = 28,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    ClockInput,
  input  logic                    ResetInput,
  input  logic                    BranchValid,
  input  logic [2:0]              BranchType,
  input  logic                    ZeroFlag,
  input  logic                    NegativeFlag,
  input  logic [OFFSET_WIDTH-1:0] RelativeOFFSET,
  input  logic [DIRECT_WIDTH-1:0] DirectBranch,
  input  logic [ADDR_WIDTH-1:0]   PCAddress,
  output logic                    BranchReady,
  output logic                    BranchSignal,
  output logic [ADDR_WIDTH-1:0]   BranchAddress,
  output logic                    FlushActive,
  output logic                    RasOverflow,
  output logic                    RasUnderflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} stateType;

  stateType               state;
  logic [CNT_W-1:0]       flushCount;
  logic [ADDR_WIDTH-1:0]  rasStore [RAS_DEPTH];
  logic [PTR_W-1:0]       topPtr;
  logic [PTR_W:0]         rasCount;

  logic                   accept;
  logic [PTR_W-1:0]       popPtr;
  logic [ADDR_WIDTH-1:0]  directTarget;
  logic [ADDR_WIDTH-1:0]  relTarget;
  logic [ADDR_WIDTH-1:0]  returnAddr;
  logic                   condTaken;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  resultAddr;
  logic                   doPush;
  logic                   doPop;
  logic                   underflow;

  assign BranchReady  = (state == IDLE);
  assign accept       = BranchValid && BranchReady;
  assign popPtr       = topPtr - PTR_W'(1);
  assign directTarget = {{(ADDR_WIDTH-DIRECT_WIDTH){1'b0}}, DirectBranch};
  assign relTarget    = PCAddress + ADDR_WIDTH'($signed(RelativeOFFSET));
  assign returnAddr   = PCAddress + ADDR_WIDTH'(4);

  // topPtr names the next slot to write, so a full stack overwrites its oldest entry.
  always_comb begin
    condTaken  = 1'b0;
    redirect   = 1'b0;
    resultAddr = '0;
    doPush     = 1'b0;
    doPop      = 1'b0;
    underflow  = 1'b0;
    case (BranchType[1:0])
      2'd0:    condTaken = ZeroFlag;
      2'd1:    condTaken = !ZeroFlag;
      2'd2:    condTaken = NegativeFlag;
      default: condTaken = !NegativeFlag;
    endcase
    case (BranchType)
      3'd1: begin
        redirect   = 1'b1;
        resultAddr = directTarget;
      end
      3'd2: begin
        redirect   = 1'b1;
        resultAddr = directTarget;
        doPush     = 1'b1;
      end
      3'd3: begin
        if (rasCount != '0) begin
          redirect   = 1'b1;
          resultAddr = rasStore[popPtr];
          doPop      = 1'b1;
        end else begin
          underflow  = 1'b1;
        end
      end
      3'd4, 3'd5, 3'd6, 3'd7: begin
        redirect   = condTaken;
        resultAddr = relTarget;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ClockInput) begin
    if (ResetInput) begin
      state         <= IDLE;
      flushCount    <= '0;
      topPtr        <= '0;
      rasCount      <= '0;
      BranchSignal  <= 1'b0;
      BranchAddress <= '0;
      FlushActive   <= 1'b0;
      RasOverflow   <= 1'b0;
      RasUnderflow  <= 1'b0;
    end else begin
      BranchSignal  <= 1'b0;
      BranchAddress <= '0;
      RasOverflow   <= 1'b0;
      RasUnderflow  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            BranchSignal  <= redirect;
            BranchAddress <= resultAddr;
            RasUnderflow  <= underflow;
            if (doPush) begin
              rasStore[topPtr] <= returnAddr;
              topPtr           <= topPtr + PTR_W'(1);
              if (rasCount == (PTR_W+1)'(RAS_DEPTH))
                RasOverflow <= 1'b1;
              else
                rasCount <= rasCount + (PTR_W+1)'(1);
            end
            if (doPop) begin
              topPtr   <= popPtr;
              rasCount <= rasCount - (PTR_W+1)'(1);
            end
            if (redirect) begin
              state       <= FLUSH;
              flushCount  <= CNT_W'(FLUSH_CYCLES);
              FlushActive <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flushCount == CNT_W'(1)) begin
            state       <= IDLE;
            flushCount  <= '0;
            FlushActive <= 1'b0;
          end else begin
            flushCount <= flushCount - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a queue-based reference model predicts each
// cycle's outputs when stimulus is driven; a monitor pops and compares after the edge.
module tb_branch_resolver;

  localparam int FLUSH_CYCLES = 2;
  localparam int RAS_DEPTH    = 4;

  logic        clock = 1'b0;
  logic        resetIn;
  logic        branchValid;
  logic [2:0]  branchType;
  logic        zeroFlag;
  logic        negativeFlag;
  logic [19:0] relOffset;
  logic [27:0] directBranch;
  logic [31:0] pcAddress;
  logic        branchReady;
  logic        branchSignal;
  logic [31:0] branchAddress;
  logic        flushActive;
  logic        rasOverflow;
  logic        rasUnderflow;

  typedef struct packed {
    logic        sig;
    logic [31:0] addr;
    logic        flush;
    logic        ovf;
    logic        udf;
    logic        ready;
  } expType;

  expType        scoreboard [$];
  logic   [31:0] modelStack [$];
  int            flushLeft = 0;
  int            assertCount = 0;
  int            failCount = 0;

  branch_resolver dut (
    .ClockInput     (clock),
    .ResetInput     (resetIn),
    .BranchValid    (branchValid),
    .BranchType     (branchType),
    .ZeroFlag       (zeroFlag),
    .NegativeFlag   (negativeFlag),
    .RelativeOFFSET (relOffset),
    .DirectBranch   (directBranch),
    .PCAddress      (pcAddress),
    .BranchReady    (branchReady),
    .BranchSignal   (branchSignal),
    .BranchAddress  (branchAddress),
    .FlushActive    (flushActive),
    .RasOverflow    (rasOverflow),
    .RasUnderflow   (rasUnderflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and predict the post-edge outputs.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [2:0] typ,
                               input logic zero, input logic neg, input logic [19:0] off,
                               input logic [27:0] dir, input logic [31:0] pc);
    expType      e;
    logic [31:0] off32;
    logic        taken;
    bit          readyNow;
    @(negedge clock);
    resetIn      = rst;
    branchValid  = valid;
    branchType   = typ;
    zeroFlag     = zero;
    negativeFlag = neg;
    relOffset    = off;
    directBranch = dir;
    pcAddress    = pc;
    e        = '0;
    readyNow = (flushLeft == 0);
    off32    = {{12{off[19]}}, off};
    if (rst) begin
      modelStack.delete();
      flushLeft = 0;
    end else if (valid && readyNow) begin
      case (typ)
        3'd1: begin
          e.sig  = 1'b1;
          e.addr = {4'h0, dir};
        end
        3'd2: begin
          e.sig  = 1'b1;
          e.addr = {4'h0, dir};
          modelStack.push_back(pc + 32'd4);
          if (modelStack.size() > RAS_DEPTH) begin
            void'(modelStack.pop_front());
            e.ovf = 1'b1;
          end
        end
        3'd3: begin
          if (modelStack.size() > 0) begin
            e.sig  = 1'b1;
            e.addr = modelStack.pop_back();
          end else begin
            e.udf = 1'b1;
          end
        end
        3'd4, 3'd5, 3'd6, 3'd7: begin
          case (typ)
            3'd4:    taken = zero;
            3'd5:    taken = !zero;
            3'd6:    taken = neg;
            default: taken = !neg;
          endcase
          e.sig  = taken;
          e.addr = pc + off32;
        end
        default: ;
      endcase
      if (e.sig) flushLeft = FLUSH_CYCLES;
    end else if (flushLeft > 0) begin
      flushLeft--;
    end
    e.flush = (flushLeft > 0);
    e.ready = (flushLeft == 0);
    scoreboard.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 20'h0, 28'h0, 32'h0);
  endtask

  always @(posedge clock) begin
    expType e;
    #1;
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkOutput("BranchSignal",  {31'b0, branchSignal}, {31'b0, e.sig});
      checkOutput("BranchAddress", branchAddress,         e.addr);
      checkOutput("FlushActive",   {31'b0, flushActive},  {31'b0, e.flush});
      checkOutput("RasOverflow",   {31'b0, rasOverflow},  {31'b0, e.ovf});
      checkOutput("RasUnderflow",  {31'b0, rasUnderflow}, {31'b0, e.udf});
      checkOutput("BranchReady",   {31'b0, branchReady},  {31'b0, e.ready});
    end
  end

  initial begin
    resetIn = 1'b1; branchValid = 1'b0; branchType = 3'd0; zeroFlag = 1'b0;
    negativeFlag = 1'b0; relOffset = '0; directBranch = '0; pcAddress = '0;

    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 20'h0, 28'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 20'h0, 28'h55, 32'h0);

    // Conditional branches: taken BEQ backward, not-taken BNE, BLT taken, BGE not taken
    applyStimulus(1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 20'hFFFF0, 28'h0, 32'h100);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 20'h00010, 28'h0, 32'h100);
    applyStimulus(1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 20'h00200, 28'h0, 32'hFFFFFF00);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 20'h00040, 28'h0, 32'h300);
    applyStimulus(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 20'h00040, 28'h77, 32'h300);

    // Nested calls then returns down to an underflow
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 20'h0, 28'h1000, 32'h40);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 20'h0, 28'h2000, 32'h80);
    idleCycles(2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 20'h0, 28'h0, 32'h0);
      idleCycles(2);
    end

    // Five calls overflow a four-entry stack, then drain it
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 20'h0, 28'h500, 32'h1000 + 32'(i * 16));
      idleCycles(2);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 20'h0, 28'h0, 32'h0);
      idleCycles(2);
    end

    // Requests during the flush window are ignored; the third one is accepted
    applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 20'h0, 28'h0ABCDEF, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 20'h0, 28'h111, 32'h600);
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 20'h0, 28'h222, 32'h700);
    applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 20'h0, 28'h333, 32'h0);
    idleCycles(2);

    // Reset mid-flush aborts the window and empties the stack
    applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 20'h0, 28'h444, 32'h900);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 20'h0, 28'h888, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 20'h0, 28'h999, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 20'h0, 28'h0, 32'h0);

    for (int i = 0; i < 60; i++)
      applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                    1'($urandom), 1'($urandom), 20'($urandom), 28'($urandom),
                    {$urandom} & 32'hFFFFFFFC);

    idleCycles(3);
    @(posedge clock);
    #2;
    checkOutput("ScoreboardDrained", 32'(scoreboard.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
